// File: rtl/arya_dmem_arbiter.sv
`default_nettype none
// arya_dmem_arbiter: round-robin arbiter sharing one single-port, one-cycle-latency data memory
// among NUM_REQ requesters, with a bounded burst lock and a saturating conflict counter.
module arya_dmem_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 64,
  parameter int MAX_BURST  = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ-1:0]            req_lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rd_valid,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]         mem_wdata,
  input  logic [DATA_WIDTH-1:0]         mem_rdata,
  input  logic                          stat_clear,
  output logic [31:0]                   conflict_cnt
);

  localparam int              PW          = $clog2(NUM_REQ);
  localparam logic [7:0]      BURST_LIMIT = 8'(MAX_BURST);
  localparam logic [PW-1:0]   LAST_IDX    = PW'(NUM_REQ - 1);

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign addr_arr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_arr[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  logic [PW-1:0]      ptr;
  logic [PW-1:0]      owner;
  logic               owner_vld;
  logic [7:0]         burst_cnt;

  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0] owner_oh;
  logic               others_req;
  logic               lock_hold;
  logic               burst_release;
  logic               locked;
  logic [PW-1:0]      ptr_eff;
  logic               win_vld;
  logic [PW-1:0]      win_idx;
  logic [3:0]         elig_cnt;
  int                 search_idx;

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] x);
    return (x == LAST_IDX) ? '0 : x + 1'b1;
  endfunction

  assign rd_data = mem_rdata;

  always_comb begin
    elig          = req & ~gnt;
    owner_oh      = NUM_REQ'(1) << owner;
    others_req    = |(req & ~owner_oh);
    lock_hold     = owner_vld & req_lock[owner];
    // A full burst only yields when someone else is actually waiting.
    burst_release = lock_hold & (burst_cnt == BURST_LIMIT) & others_req;
    locked        = lock_hold & ~burst_release;
    cand          = locked ? (elig & owner_oh) : elig;
    ptr_eff       = (owner_vld && !locked) ? next_idx(owner) : ptr;

    win_vld    = 1'b0;
    win_idx    = '0;
    search_idx = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      search_idx = int'(ptr_eff) + k;
      if (search_idx >= NUM_REQ) search_idx = search_idx - NUM_REQ;
      if (!win_vld && cand[search_idx]) begin
        win_vld = 1'b1;
        win_idx = PW'(search_idx);
      end
    end

    elig_cnt = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      elig_cnt = elig_cnt + 4'(elig[k]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt       <= '0;
      rd_valid  <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ptr       <= '0;
      owner     <= '0;
      owner_vld <= 1'b0;
      burst_cnt <= '0;
    end else begin
      gnt      <= '0;
      mem_en   <= win_vld;
      mem_we   <= 1'b0;
      rd_valid <= (mem_en && !mem_we) ? gnt : '0;
      if (win_vld) begin
        gnt       <= NUM_REQ'(1) << win_idx;
        mem_we    <= req_we[win_idx];
        mem_addr  <= addr_arr[win_idx];
        mem_wdata <= wdata_arr[win_idx];
      end

      if (locked) begin
        if (win_vld && (burst_cnt != BURST_LIMIT)) burst_cnt <= burst_cnt + 8'd1;
      end else begin
        owner_vld <= 1'b0;
        burst_cnt <= '0;
        if (win_vld) begin
          ptr <= next_idx(win_idx);
          if (req_lock[win_idx]) begin
            owner_vld <= 1'b1;
            owner     <= win_idx;
            burst_cnt <= 8'd1;
          end
        end else begin
          ptr <= ptr_eff;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conflict_cnt <= '0;
    end else if (stat_clear) begin
      conflict_cnt <= '0;
    end else if ((elig_cnt >= 4'd2) && (conflict_cnt != 32'hFFFF_FFFF)) begin
      conflict_cnt <= conflict_cnt + 32'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_arya_dmem_arbiter.sv
`default_nettype none
// tb_arya_dmem_arbiter: directed self-checking bench for arya_dmem_arbiter.
module tb_arya_dmem_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int ADDR_WIDTH = 9;
  localparam int DATA_WIDTH = 64;

  logic                          clk = 1'b0;
  logic                          reset;
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            req_we;
  logic [NUM_REQ-1:0]            req_lock;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            rd_valid;
  logic [DATA_WIDTH-1:0]         rd_data;
  logic                          mem_en;
  logic                          mem_we;
  logic [ADDR_WIDTH-1:0]         mem_addr;
  logic [DATA_WIDTH-1:0]         mem_wdata;
  logic [DATA_WIDTH-1:0]         mem_rdata;
  logic                          stat_clear;
  logic [31:0]                   conflict_cnt;

  int checks = 0;
  int errors = 0;
  int rem2;
  int grants2_before3;
  logic seen3;
  logic [NUM_REQ-1:0] exp_gnt;

  arya_dmem_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .MAX_BURST(8)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .rd_valid(rd_valid),
    .rd_data(rd_data), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stat_clear(stat_clear),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  // Memory model: read data is a fixed pattern of the address, one cycle after the access.
  always @(posedge clk) begin
    if (mem_en && !mem_we) mem_rdata <= {23'h0, mem_addr, 32'hC0DE_FACE};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; req = '0; req_we = '0; req_lock = '0;
    req_addr = '0; req_wdata = '0; stat_clear = 1'b0;
    #2;
    check("rst_gnt", gnt, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_cnt", conflict_cnt, 0);
    step(); step();
    reset = 1'b1;
    step();

    // Lone read
    req[1] = 1'b1; req_we[1] = 1'b0; req_addr[1*ADDR_WIDTH +: ADDR_WIDTH] = 9'h010;
    step();
    check("t1_gnt", gnt, 4'b0010);
    check("t1_mem_en", mem_en, 1);
    check("t1_mem_we", mem_we, 0);
    check("t1_mem_addr", mem_addr, 9'h010);
    req[1] = 1'b0;
    step();
    check("t1_rd_valid", rd_valid, 4'b0010);
    check("t1_rd_data", rd_data, 64'h0000_0010_C0DE_FACE);
    check("t1_gnt_idle", gnt, 0);
    step();
    check("t1_rd_valid_off", rd_valid, 0);

    // Full contention round robin
    do_reset();
    req = 4'hF;
    for (int k = 1; k <= 8; k++) begin
      step();
      exp_gnt = 4'(1) << ((k - 1) % 4);
      check("t2_gnt", gnt, exp_gnt);
      check("t2_cnt", conflict_cnt, k);
    end
    req = '0;
    step(); step();

    // Burst lock on requester 2 with requester 3 waiting
    do_reset();
    rem2 = 12; grants2_before3 = 0; seen3 = 1'b0;
    req[2] = 1'b1; req_lock[2] = 1'b1; req[3] = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      step();
      if (c == 16) exp_gnt = 4'b1000;
      else if ((c % 2 == 1) && (c <= 23)) exp_gnt = 4'b0100;
      else exp_gnt = 4'b0000;
      check("t3_gnt", gnt, exp_gnt);
      if (gnt[3]) begin
        seen3 = 1'b1;
        req[3] = 1'b0;
      end
      if (gnt[2]) begin
        if (!seen3) grants2_before3++;
        rem2--;
        if (rem2 == 0) begin
          req[2] = 1'b0; req_lock[2] = 1'b0;
        end
      end
    end
    check("t3_burst_len", grants2_before3, 8);
    check("t3_all_served", rem2, 0);

    // Write
    req[0] = 1'b1; req_we[0] = 1'b1;
    req_addr[0 +: ADDR_WIDTH] = 9'h1FF;
    req_wdata[0 +: DATA_WIDTH] = 64'hDEADBEEF_00C0FFEE;
    step();
    check("t4_gnt", gnt, 4'b0001);
    check("t4_mem_en", mem_en, 1);
    check("t4_mem_we", mem_we, 1);
    check("t4_mem_addr", mem_addr, 9'h1FF);
    check("t4_mem_wdata", mem_wdata, 64'hDEADBEEF_00C0FFEE);
    req[0] = 1'b0; req_we[0] = 1'b0;
    step();
    check("t4_rd_valid", rd_valid, 0);
    check("t4_mem_en_off", mem_en, 0);
    step();
    check("t4_rd_valid2", rd_valid, 0);

    // Reset during an outstanding read
    req[1] = 1'b1; req_addr[1*ADDR_WIDTH +: ADDR_WIDTH] = 9'h020;
    step();
    check("t5_gnt", gnt, 4'b0010);
    req[1] = 1'b0;
    reset = 1'b0;
    #1;
    check("t5_gnt_rst", gnt, 0);
    check("t5_mem_en_rst", mem_en, 0);
    check("t5_mem_we_rst", mem_we, 0);
    check("t5_mem_addr_rst", mem_addr, 0);
    check("t5_mem_wdata_rst", mem_wdata, 0);
    check("t5_rd_valid_rst", rd_valid, 0);
    check("t5_cnt_rst", conflict_cnt, 0);
    step();
    check("t5_rd_valid_hold", rd_valid, 0);
    reset = 1'b1;
    step();
    check("t5_rd_dropped", rd_valid, 0);
    req = 4'hF;
    step();
    check("t5_ptr_zero", gnt, 4'b0001);
    req = '0;
    step(); step();

    // Saturation and clear of the conflict counter
    req = 4'hF;
    step();
    force dut.conflict_cnt = 32'hFFFF_FFFF;
    step();
    release dut.conflict_cnt;
    check("t6_sat_a", conflict_cnt, 32'hFFFF_FFFF);
    step();
    check("t6_sat_b", conflict_cnt, 32'hFFFF_FFFF);
    stat_clear = 1'b1;
    step();
    check("t6_clear", conflict_cnt, 0);
    stat_clear = 1'b0;
    step();
    check("t6_restart", conflict_cnt, 1);
    req = '0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
